// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32 subset control FSM.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ALUOP_ITYPE = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_WB_ALU = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_TRAP   = 4'd10
  } state_e;

  // Instruction class captured in DECODE; ADDR uses it to pick load vs store.
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_ALU   = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } op_class_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_controller_if;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic       MemtoReg;
  logic       retire;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state_dbg;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, ALUSrcA, ALUSrcB,
           ALUOp, RegWrite, MemtoReg, retire, trap, trap_cause, state_dbg
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, ALUSrcA, ALUSrcB,
           ALUOp, RegWrite, MemtoReg, retire, trap, trap_cause, state_dbg
  );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts wait cycles of a pending memory request and flags a timeout.
// The count drops to zero whenever no request is pending or the request
// completes, so every FETCH/MEM_RD/MEM_WR visit starts from zero.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam bit                   ENABLE = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] LIMIT  = TIMEOUT_W'(MEM_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Next count: clear when idle or done, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // A completing request in the final allowed cycle beats the timeout.
  assign timeout_o = ENABLE && active_i && !ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM for the RV32 R/I/load/store datapath.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_e    state_q, state_d;
  op_class_e cls_q, cls_d;
  logic [1:0] cause_q, cause_d;
  logic       wait_active;
  logic       timeout;

  assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                       (state_q == ST_MEM_WR);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .active_i  (wait_active),
    .ready_i   (bus.mem_ready),
    .timeout_o (timeout)
  );

  // State, opcode-class and trap-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cls_q   <= CLS_NONE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cause_d      = cause_q;
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_RS2;
    bus.ALUOp    = ALUOP_ITYPE;
    bus.RegWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.retire   = 1'b0;
    bus.trap     = 1'b0;

    unique case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.ALUOp   = ALUOP_ADD;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE: begin cls_d = CLS_ALU;   state_d = ST_EXEC_R; end
          OP_ITYPE: begin cls_d = CLS_ALU;   state_d = ST_EXEC_I; end
          OP_LOAD:  begin cls_d = CLS_LOAD;  state_d = ST_ADDR;   end
          OP_STORE: begin cls_d = CLS_STORE; state_d = ST_ADDR;   end
          default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_RS2;
        bus.ALUOp   = ALUOP_RTYPE;
        state_d     = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_ITYPE;
        state_d     = ST_WB_ALU;
      end
      ST_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_ADD;
        state_d     = (cls_q == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_WB_MEM;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_MEM_WR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        bus.retire   = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB_ALU: begin
        bus.RegWrite = 1'b1;
        bus.retire   = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.retire   = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_TRAP: bus.trap = 1'b1;
      default: state_d = ST_RST;
    endcase
  end

  assign bus.trap_cause = cause_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: every cycle compares the state
// and a packed vector of all control outputs against hand-written values.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  multicycle_controller_if bus ();

  multicycle_controller #(
    .MEM_TIMEOUT (16),
    .TIMEOUT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PCWrite, IRWrite, IorD, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp,
  //  RegWrite, MemtoReg, retire, trap, trap_cause}
  logic [15:0] obs;
  assign obs = {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite,
                bus.MemtoReg, bus.retire, bus.trap, bus.trap_cause};

  localparam logic [15:0] V_ZERO    = 16'h0000;
  localparam logic [15:0] V_FETCH   = 16'h1140;
  localparam logic [15:0] V_FETCH_R = 16'hD140;
  localparam logic [15:0] V_EXEC_R  = 16'h0480;
  localparam logic [15:0] V_EXEC_I  = 16'h0600;
  localparam logic [15:0] V_ADDR    = 16'h0640;
  localparam logic [15:0] V_MEM_RD  = 16'h3000;
  localparam logic [15:0] V_MEM_WR  = 16'h2800;
  localparam logic [15:0] V_MEM_WRR = 16'h2808;
  localparam logic [15:0] V_WB_ALU  = 16'h0028;
  localparam logic [15:0] V_WB_MEM  = 16'h0038;
  localparam logic [15:0] V_TRAP_IL = 16'h0005;
  localparam logic [15:0] V_TRAP_TO = 16'h0006;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BAD = 7'b1111111;

  task automatic chk(input string tag, input logic [3:0] st, input logic [15:0] vec);
    checks++;
    assert (bus.state_dbg === st && obs === vec)
    else begin
      errors++;
      $error("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
             tag, bus.state_dbg, obs, st, vec);
    end
  endtask

  // Advance one clock, apply this cycle's inputs, then compare.
  task automatic step(input string tag, input logic rdy, input logic [6:0] op,
                      input logic [3:0] st, input logic [15:0] vec);
    @(posedge clk);
    #1;
    bus.mem_ready = rdy;
    bus.Opcode    = op;
    #1;
    chk(tag, st, vec);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Opcode    = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset", 4'd0, V_ZERO);
    rst_n = 1'b1;
    #1;
    chk("rst_state", 4'd0, V_ZERO);

    // R-type, zero-wait memory
    step("r_fetch",  1'b1, R, 4'd1, V_FETCH_R);
    step("r_decode", 1'b1, R, 4'd2, V_ZERO);
    step("r_exec",   1'b1, R, 4'd3, V_EXEC_R);
    step("r_wb",     1'b1, R, 4'd8, V_WB_ALU);

    // I-type
    step("i_fetch",  1'b1, I, 4'd1, V_FETCH_R);
    step("i_decode", 1'b1, I, 4'd2, V_ZERO);
    step("i_exec",   1'b1, I, 4'd4, V_EXEC_I);
    step("i_wb",     1'b1, I, 4'd8, V_WB_ALU);

    // Load with three wait cycles in MEM_RD
    step("ld_fetch",  1'b1, LD, 4'd1, V_FETCH_R);
    step("ld_decode", 1'b1, LD, 4'd2, V_ZERO);
    step("ld_addr",   1'b1, LD, 4'd5, V_ADDR);
    step("ld_wait1",  1'b0, LD, 4'd6, V_MEM_RD);
    step("ld_wait2",  1'b0, LD, 4'd6, V_MEM_RD);
    step("ld_wait3",  1'b0, LD, 4'd6, V_MEM_RD);
    step("ld_done",   1'b1, LD, 4'd6, V_MEM_RD);
    step("ld_wb",     1'b1, LD, 4'd9, V_WB_MEM);

    // Store; opcode changed after DECODE must be ignored
    step("st_fetch",  1'b1, ST, 4'd1, V_FETCH_R);
    step("st_decode", 1'b1, ST, 4'd2, V_ZERO);
    step("st_addr",   1'b1, R,  4'd5, V_ADDR);
    step("st_wait",   1'b0, R,  4'd7, V_MEM_WR);
    step("st_done",   1'b1, R,  4'd7, V_MEM_WRR);

    // Fetch timeout: 16 cycles without mem_ready
    step("to_fetch1", 1'b0, R, 4'd1, V_FETCH);
    for (int c = 2; c <= 16; c++) step("to_fetch", 1'b0, R, 4'd1, V_FETCH);
    step("to_trap", 1'b0, R, 4'd10, V_TRAP_TO);
    for (int c = 0; c < 20; c++)
      step("to_hold", 1'($urandom), 7'($urandom), 4'd10, V_TRAP_TO);

    // Reset pulse recovers from trap
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("trap_rst", 4'd0, V_ZERO);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("trap_rst_rel", 4'd0, V_ZERO);

    // mem_ready on the 16th FETCH cycle wins over timeout
    step("edge_fetch1", 1'b0, BAD, 4'd1, V_FETCH);
    for (int c = 2; c <= 15; c++) step("edge_fetch", 1'b0, BAD, 4'd1, V_FETCH);
    step("edge_fetch16", 1'b1, BAD, 4'd1, V_FETCH_R);

    // Illegal opcode traps with cause 01 and holds
    step("ill_decode", 1'b1, BAD, 4'd2, V_ZERO);
    step("ill_trap",   1'b1, BAD, 4'd10, V_TRAP_IL);
    for (int c = 0; c < 20; c++)
      step("ill_hold", 1'($urandom), 7'($urandom), 4'd10, V_TRAP_IL);

    // Reset mid-store abandons the write immediately
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rel", 4'd0, V_ZERO);
    step("mid_fetch",  1'b1, ST, 4'd1, V_FETCH_R);
    step("mid_decode", 1'b1, ST, 4'd2, V_ZERO);
    step("mid_addr",   1'b0, ST, 4'd5, V_ADDR);
    step("mid_wr",     1'b0, ST, 4'd7, V_MEM_WR);
    rst_n = 1'b0;
    #1;
    chk("mid_abort", 4'd0, V_ZERO);
    @(posedge clk);
    #1;
    chk("mid_held", 4'd0, V_ZERO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
